// File: rtl/riscv_cpu_pkg.sv
// Shared fetch-path types and constants: word size, instruction alignment and
// the {pc, instr} entry carried through the fetch buffer.
package riscv_cpu_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_ALIGN = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(INSTR_ALIGN - 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Registered instruction buffer between the memory response path and decode.
// Simultaneous push and pop are accepted at any fill level; flush wins over both.
module fetch_fifo
  import riscv_cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == LAST) ? '0 : ptr + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  // Storage is not reset; an empty buffer presents zeros instead.
  assign head = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + ONE;
      else if (!do_push && do_pop) count <= count - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited request issue, in-order response tracking,
// redirect with discard of stale responses, and a small decode-side buffer.
module fetch_unit
  import riscv_cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            instr_req_o,
  output logic [XLEN-1:0] instr_addr_o,
  input  logic            instr_gnt_i,
  input  logic            instr_rvalid_i,
  input  logic [XLEN-1:0] instr_rdata_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            instr_ready_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] branch_target_i
);

  localparam int              CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]     CREDITS = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0]   ONE     = CW'(1);
  localparam logic [XLEN-1:0] STEP    = XLEN'(INSTR_ALIGN);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_nxt;
  logic [CW-1:0]   discard_cnt;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            grant;
  logic            rsp;
  logic            drop;
  logic            push;
  logic            pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    fifo_head;

  // Discarded responses still hold credit, so the counters can never exceed FIFO_DEPTH.
  assign instr_req_o  = rst_ni && !branch_i && !fifo_full &&
                        (({1'b0, outstanding} + {1'b0, fifo_count}) < CREDITS);
  assign instr_addr_o = fetch_pc;

  assign grant = instr_req_o && instr_gnt_i;
  assign rsp   = instr_rvalid_i && (outstanding != '0);
  assign drop  = rsp && (discard_cnt != '0);
  assign push  = rsp && !drop && !branch_i;
  assign pop   = !fifo_empty && instr_ready_i && !branch_i;

  assign push_entry.pc    = rsp_pc;
  assign push_entry.instr = instr_rdata_i;

  always_comb begin
    outstanding_nxt = outstanding;
    if (grant && !rsp)      outstanding_nxt = outstanding + ONE;
    else if (!grant && rsp) outstanding_nxt = outstanding - ONE;
  end

  // rsp_pc is the address of the next response that will be kept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc    <= BOOT_ADDR;
      rsp_pc      <= BOOT_ADDR;
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (branch_i) begin
        fetch_pc    <= align_pc(branch_target_i);
        rsp_pc      <= align_pc(branch_target_i);
        discard_cnt <= outstanding_nxt;
      end else begin
        if (grant) fetch_pc    <= fetch_pc + STEP;
        if (push)  rsp_pc      <= rsp_pc + STEP;
        if (drop)  discard_cnt <= discard_cnt - ONE;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (branch_i),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign instr_valid_o = !fifo_empty;
  assign instr_o       = fifo_head.instr;
  assign pc_o          = fifo_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scenario tasks plus a queue-based
// reference model of the instruction stream and credit rule.
module tb_fetch_unit;

  localparam logic [31:0] BOOT  = 32'h0000_0000;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_ready_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_target_i = '0;

  always #5 clk = ~clk;

  fetch_unit #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .instr_req_o     (instr_req_o),
    .instr_addr_o    (instr_addr_o),
    .instr_gnt_i     (instr_gnt_i),
    .instr_rvalid_i  (instr_rvalid_i),
    .instr_rdata_i   (instr_rdata_i),
    .instr_valid_o   (instr_valid_o),
    .instr_o         (instr_o),
    .pc_o            (pc_o),
    .instr_ready_i   (instr_ready_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i)
  );

  typedef struct { logic [31:0] addr; bit live; } flight_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  flight_t     inflight[$];
  logic [31:0] dq[$];
  logic [31:0] fptr;
  mreq_t       mem_q[$];
  logic [31:0] grant_log[$];
  int          grant_cyc[$];
  logic [31:0] consumed_log[$];
  int cyc = 0, first_valid_cyc = -1, checks = 0, passed = 0;
  int gnt_prob = 0, ready_prob = 0, lat_min = 1, lat_max = 1;
  bit branch_now = 0, stray_now = 0;
  logic [31:0] branch_tgt = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic void model_reset();
    inflight.delete();
    dq.delete();
    mem_q.delete();
    fptr = BOOT;
  endfunction

  task automatic idle_inputs();
    instr_gnt_i = 0; instr_ready_i = 0; instr_rvalid_i = 0; instr_rdata_i = '0;
    branch_i = 0; branch_target_i = '0;
  endtask

  // One clock: drive inputs, compare against the model, advance model and memory.
  task automatic step();
    bit gnt_v, rdy_v, exp_req, exp_valid, resp, consume;
    flight_t f;
    gnt_v = ($urandom_range(99) < gnt_prob);
    rdy_v = ($urandom_range(99) < ready_prob);
    instr_gnt_i = gnt_v; instr_ready_i = rdy_v;
    branch_i = branch_now; branch_target_i = branch_tgt;
    if (stray_now) begin
      instr_rvalid_i = 1; instr_rdata_i = 32'hDEAD_BEEF;
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      instr_rvalid_i = 1; instr_rdata_i = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      instr_rvalid_i = 0; instr_rdata_i = $urandom;
    end
    #1;
    exp_valid = (dq.size() != 0);
    exp_req   = ((inflight.size() + dq.size()) < DEPTH) && !branch_now;
    checks++;
    if (instr_valid_o !== exp_valid)
      $display("FAIL valid cyc=%0d got=%b want=%b", cyc, instr_valid_o, exp_valid);
    else passed++;
    checks++;
    if (instr_req_o !== exp_req)
      $display("FAIL req cyc=%0d got=%b want=%b", cyc, instr_req_o, exp_req);
    else passed++;
    if (exp_req) begin
      checks++;
      if (instr_addr_o !== fptr)
        $display("FAIL addr cyc=%0d got=%h want=%h", cyc, instr_addr_o, fptr);
      else passed++;
    end
    if (exp_valid) begin
      checks++;
      if (pc_o !== dq[0] || instr_o !== mem_word(dq[0]))
        $display("FAIL head cyc=%0d got pc=%h instr=%h want pc=%h instr=%h",
                 cyc, pc_o, instr_o, dq[0], mem_word(dq[0]));
      else passed++;
    end
    if (first_valid_cyc < 0 && instr_valid_o === 1'b1) first_valid_cyc = cyc;
    if (instr_valid_o === 1'b1 && rdy_v && !branch_now) consumed_log.push_back(pc_o);
    if (instr_req_o === 1'b1 && gnt_v) begin
      grant_log.push_back(instr_addr_o);
      grant_cyc.push_back(cyc);
      mem_q.push_back('{addr: instr_addr_o,
                        due: cyc + int'($urandom_range(lat_max, lat_min))});
    end
    resp    = instr_rvalid_i && (inflight.size() != 0);
    consume = exp_valid && rdy_v && !branch_now;
    if (consume) void'(dq.pop_front());
    if (resp) begin
      f = inflight.pop_front();
      if (f.live && !branch_now) dq.push_back(f.addr);
    end
    if (branch_now) begin
      dq.delete();
      foreach (inflight[i]) inflight[i].live = 0;
      fptr = {branch_tgt[31:2], 2'b00};
    end
    if (exp_req && gnt_v) begin
      inflight.push_back('{addr: fptr, live: 1'b1});
      fptr = fptr + 32'd4;
    end
    branch_now = 0; stray_now = 0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_ni = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    model_reset();
    rst_ni = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rst_ni = 0;
    #1;
    checks++; if (instr_req_o !== 1'b0) $display("FAIL rst_req got=%b want=0", instr_req_o); else passed++;
    checks++; if (instr_valid_o !== 1'b0) $display("FAIL rst_valid got=%b want=0", instr_valid_o); else passed++;
    checks++; if (instr_addr_o !== BOOT) $display("FAIL rst_addr got=%h want=%h", instr_addr_o, BOOT); else passed++;
    checks++; if (instr_o !== 32'h0) $display("FAIL rst_instr got=%h want=0", instr_o); else passed++;
    checks++; if (pc_o !== 32'h0) $display("FAIL rst_pc got=%h want=0", pc_o); else passed++;
    repeat (2) @(negedge clk);
    model_reset();
    rst_ni = 1;
  endtask

  task automatic test_stream();
    apply_reset();
    gnt_prob = 100; ready_prob = 100; lat_min = 1; lat_max = 1;
    grant_log.delete(); grant_cyc.delete(); consumed_log.delete(); first_valid_cyc = -1;
    repeat (10) step();
    checks++;
    if (grant_log.size() < 3 || grant_log[0] !== 32'h0 || grant_log[1] !== 32'h4 || grant_log[2] !== 32'h8)
      $display("FAIL stream_addrs got %0d grants first=%h want 0,4,8", grant_log.size(),
               (grant_log.size() > 0) ? grant_log[0] : 32'hFFFF_FFFF);
    else passed++;
    checks++;
    if (grant_cyc.size() == 0 || first_valid_cyc != grant_cyc[0] + 2)
      $display("FAIL stream_latency got valid at %0d want %0d", first_valid_cyc,
               (grant_cyc.size() > 0) ? grant_cyc[0] + 2 : -1);
    else passed++;
    checks++;
    if (consumed_log.size() == 0 || consumed_log[0] !== 32'h0)
      $display("FAIL stream_first_pc got %h want 0", (consumed_log.size() > 0) ? consumed_log[0] : 32'hFFFF_FFFF);
    else passed++;
  endtask

  task automatic test_backpressure();
    apply_reset();
    gnt_prob = 100; ready_prob = 0; lat_min = 1; lat_max = 1;
    grant_log.delete();
    repeat (8) step();
    checks++;
    if (grant_log.size() != DEPTH) $display("FAIL bp_grants got=%0d want=%0d", grant_log.size(), DEPTH);
    else passed++;
    checks++; if (instr_valid_o !== 1'b1) $display("FAIL bp_full_valid got=%b want=1", instr_valid_o); else passed++;
    checks++; if (instr_req_o !== 1'b0) $display("FAIL bp_req got=%b want=0", instr_req_o); else passed++;
    ready_prob = 100; consumed_log.delete();
    repeat (8) step();
    checks++;
    if (consumed_log.size() < 3 || consumed_log[0] !== 32'h0 || consumed_log[1] !== 32'h4 || consumed_log[2] !== 32'h8)
      $display("FAIL bp_no_loss got %0d words first=%h want 0,4,8", consumed_log.size(),
               (consumed_log.size() > 0) ? consumed_log[0] : 32'hFFFF_FFFF);
    else passed++;
  endtask

  task automatic test_branch();
    apply_reset();
    gnt_prob = 100; ready_prob = 100; lat_min = 3; lat_max = 3;
    step(); step();
    branch_now = 1; branch_tgt = 32'h0000_1002;
    step();
    checks++; if (instr_valid_o !== 1'b0) $display("FAIL br_valid_after got=%b want=0", instr_valid_o); else passed++;
    lat_min = 1; lat_max = 1;
    consumed_log.delete(); grant_log.delete();
    repeat (12) step();
    checks++;
    if (consumed_log.size() == 0 || consumed_log[0] !== 32'h0000_1000)
      $display("FAIL br_first_pc got %h want 00001000", (consumed_log.size() > 0) ? consumed_log[0] : 32'hFFFF_FFFF);
    else passed++;
    checks++;
    if (grant_log.size() == 0 || grant_log[0] !== 32'h0000_1000)
      $display("FAIL br_first_req got %h want 00001000", (grant_log.size() > 0) ? grant_log[0] : 32'hFFFF_FFFF);
    else passed++;
  endtask

  task automatic test_gnt_stall();
    apply_reset();
    gnt_prob = 100; ready_prob = 100; lat_min = 1; lat_max = 1;
    step();
    gnt_prob = 0;
    repeat (5) begin
      step();
      checks++;
      if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h4)
        $display("FAIL stall_hold got req=%b addr=%h want req=1 addr=00000004", instr_req_o, instr_addr_o);
      else passed++;
    end
    gnt_prob = 100; grant_log.delete();
    step();
    checks++;
    if (grant_log.size() != 1 || grant_log[0] !== 32'h4)
      $display("FAIL stall_single got %0d grants want 1 at 00000004", grant_log.size());
    else passed++;
    repeat (6) step();
  endtask

  task automatic test_wrap();
    apply_reset();
    gnt_prob = 100; ready_prob = 100; lat_min = 1; lat_max = 1;
    step(); step();
    branch_now = 1; branch_tgt = 32'hFFFF_FFFC;
    step();
    grant_log.delete(); consumed_log.delete();
    repeat (8) step();
    checks++;
    if (grant_log.size() < 2 || grant_log[0] !== 32'hFFFF_FFFC || grant_log[1] !== 32'h0)
      $display("FAIL wrap_addrs got %0d grants first=%h want FFFFFFFC,00000000", grant_log.size(),
               (grant_log.size() > 0) ? grant_log[0] : 32'h1);
    else passed++;
    checks++;
    if (consumed_log.size() < 2 || consumed_log[0] !== 32'hFFFF_FFFC || consumed_log[1] !== 32'h0)
      $display("FAIL wrap_pcs got %0d words want FFFFFFFC then 00000000", consumed_log.size());
    else passed++;
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    gnt_prob = 100; ready_prob = 100; lat_min = 6; lat_max = 6;
    step();
    gnt_prob = 0;
    step();
    #2 rst_ni = 0;
    #1;
    checks++; if (instr_req_o !== 1'b0) $display("FAIL mid_rst_req got=%b want=0", instr_req_o); else passed++;
    checks++; if (instr_addr_o !== BOOT) $display("FAIL mid_rst_addr got=%h want=%h", instr_addr_o, BOOT); else passed++;
    @(negedge clk);
    rst_ni = 1;
    model_reset();
    stray_now = 1;
    step();
    checks++; if (instr_valid_o !== 1'b0) $display("FAIL stray_valid got=%b want=0", instr_valid_o); else passed++;
    gnt_prob = 100; lat_min = 1; lat_max = 1;
    consumed_log.delete();
    repeat (8) step();
    checks++;
    if (consumed_log.size() == 0 || consumed_log[0] !== BOOT)
      $display("FAIL mid_restart got %h want %h", (consumed_log.size() > 0) ? consumed_log[0] : 32'hFFFF_FFFF, BOOT);
    else passed++;
  endtask

  task automatic test_random();
    apply_reset();
    gnt_prob = 60; ready_prob = 60; lat_min = 1; lat_max = 4;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(99) < 4) begin
        branch_now = 1;
        branch_tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      end else if (mem_q.size() == 0 && inflight.size() == 0 && $urandom_range(99) < 5) begin
        stray_now = 1;
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_branch();
    test_gnt_stall();
    test_wrap();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter BOOT_ADDR, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 2, giving the instruction buffer depth and the credit limit.
REQ-003 The block SHALL have port clk_i, input, 1, the single clock.
REQ-004 The block SHALL have port rst_ni, input, 1, reset; asynchronous, active-low.
REQ-005 The block SHALL have port instr_req_o, input/output direction output, 1, memory fetch request.
REQ-006 The block SHALL have port instr_addr_o, output, 32, fetch word address.
REQ-007 The block SHALL have port instr_gnt_i, input, 1, memory accepts the request this cycle.
REQ-008 The block SHALL have port instr_rvalid_i, input, 1, read data valid, in request order.
REQ-009 The block SHALL have port instr_rdata_i, input, 32, fetched instruction word.
REQ-010 The block SHALL have port instr_valid_o, output, 1, instruction available to the control unit.
REQ-011 The block SHALL have port instr_o, output, 32, instruction word fed to the control unit instr_i.
REQ-012 The block SHALL have port pc_o, output, 32, address of instr_o.
REQ-013 The block SHALL have port instr_ready_i, input, 1, decode consumes instr_o this cycle.
REQ-014 The block SHALL have port branch_i, input, 1, redirect fetch.
REQ-015 The block SHALL have port branch_target_i, input, 32, redirect address.

Function
REQ-016 The block SHALL assert instr_req_o whenever outstanding + fifo_count < FIFO_DEPTH and branch_i is low.
REQ-017 The block SHALL hold instr_req_o and instr_addr_o stable until instr_gnt_i, except on redirect.
REQ-018 On instr_req_o & instr_gnt_i, the block SHALL advance fetch_pc by 4 (mod 2^32, wrap from 32'hFFFF_FFFC to 0) and increment outstanding.
REQ-019 On instr_rvalid_i, the block SHALL decrement outstanding; it SHALL drop the word if discard_cnt > 0 (decrementing discard_cnt), otherwise push {pc, rdata} into the FIFO.
REQ-020 instr_valid_o SHALL be fifo not-empty; instr_o/pc_o SHALL be the FIFO head; a pop SHALL occur on instr_valid_o & instr_ready_i.
REQ-021 Latency: rvalid in cycle N SHALL yield instr_valid_o in cycle N+1 (registered FIFO, no bypass).
REQ-022 Push and pop in the same cycle SHALL be legal at any fill level, including full.
REQ-023 On branch_i, the block SHALL flush the FIFO, set fetch_pc to {branch_target_i[31:2],2'b00}, and set discard_cnt to outstanding after this cycle's grant/rvalid updates.
REQ-024 branch_i SHALL take priority over a same-cycle pop and push; instr_valid_o SHALL be low the cycle after branch_i.
REQ-025 The first request after branch_i SHALL be issued in the following cycle at the new target.
REQ-026 instr_rvalid_i with outstanding = 0 SHALL be ignored with no state change.
REQ-027 Counters SHALL be $clog2(FIFO_DEPTH+1) bits wide and never overflow given REQ-016.

Reset
REQ-028 While rst_ni is low, the block SHALL force fetch_pc = BOOT_ADDR, FIFO empty, outstanding = 0, discard_cnt = 0.
REQ-029 Outputs during reset SHALL be instr_req_o = 0, instr_valid_o = 0, instr_addr_o = BOOT_ADDR, instr_o = 0, pc_o = 0.
REQ-030 Reset asserted mid-transaction SHALL abandon all in-flight requests; the first request SHALL follow in the first cycle after release.

Structure
REQ-031 riscv_cpu_pkg SHALL hold the fetch entry struct {pc, instr}, and the constants XLEN = 32 and INSTR_ALIGN = 4.
REQ-032 The FIFO SHALL be a separate sub-module named fetch_fifo, with push/pop/flush, full/empty and count ports.

Verification
REQ-033 Reset release, gnt tied high, rvalid one cycle after gnt, ready high -> requests at 0x0, 0x4, 0x8, and instr_valid_o with pc_o = 0x0 two cycles after the first gnt.
REQ-034 ready low with memory responding -> at most 2 requests granted, FIFO full, instr_req_o low, no word lost after ready rises.
REQ-035 branch_i to 0x0000_1002 with 2 outstanding -> both late rvalids dropped, next pc_o = 0x0000_1000, instr_valid_o low the cycle after the branch.
REQ-036 gnt held low for 5 cycles -> instr_addr_o constant at 0x4 throughout, single request counted.
REQ-037 Branch to 0xFFFF_FFFC -> fetches at 0xFFFF_FFFC then 0x0000_0000.
REQ-038 rst_ni pulsed low with 1 outstanding, then stray rvalid after release -> rvalid ignored, fetch restarts at BOOT_ADDR.
